// File: rtl/dual_buffer_pkg.sv
// Shared types and width helpers for the ping-pong packet buffer and the packer
// that feeds it.
package dual_buffer_pkg;

  // Storage is built from fixed-width lanes, so DATA_WIDTH must be a lane multiple.
  localparam int LANE_WIDTH = 4000;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  // Address width of one half; a half always holds at least two packets.
  function automatic int addr_width(input int num_packets);
    return (num_packets > 1) ? $clog2(num_packets) : 1;
  endfunction

  // The count width is one bit wider than the address, so a full half (N) fits.
  function automatic int count_width(input int num_packets);
    return addr_width(num_packets) + 1;
  endfunction

endpackage

// File: rtl/dual_buffer_bram.sv
// Two-half packet store with one write port and a registered read port that has
// one cycle of latency. The halves are selected by the top address bit.
module dual_buffer_bram
  import dual_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 16000,
  parameter int AW         = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  wr_buf_sel,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_buf_sel,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int LANES = DATA_WIDTH / LANE_WIDTH;
  localparam int DEPTH = 2 << AW;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [LANE_WIDTH-1:0] mem [DEPTH];
    logic [LANE_WIDTH-1:0] rd_q;

    // NOTE: the array has no reset so it can map onto block RAM; its contents
    // after reset are don't-care, and only the read register below is cleared.
    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem[{wr_buf_sel, wr_addr}] <= wr_data[g*LANE_WIDTH +: LANE_WIDTH];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_q <= '0;
      end else begin
        rd_q <= mem[{rd_buf_sel, rd_addr}];
      end
    end

    assign rd_data[g*LANE_WIDTH +: LANE_WIDTH] = rd_q;
  end

endmodule

// File: rtl/dual_buffer_ctrl.sv
// Ping-pong sequencer: the write side fills one half while the read side drains
// the other, sealed half to a valid/ready consumer in seal order.
module dual_buffer_ctrl
  import dual_buffer_pkg::*;
#(
  parameter  int DATA_WIDTH             = 16000,
  parameter  int NUM_PACKETS_PER_BUFFER = 8,
  localparam int AW                     = addr_width(NUM_PACKETS_PER_BUFFER),
  localparam int CW                     = count_width(NUM_PACKETS_PER_BUFFER)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [CW-1:0]         out_len,
  output logic                  out_buf
);

  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_PACKETS_PER_BUFFER - 1);

  // Write side state
  logic          wbuf;
  logic [CW-1:0] wcnt;
  logic [1:0]    full;
  logic [CW-1:0] len [2];

  // Read side state
  rd_state_t     rstate;
  rd_state_t     rstate_nxt;
  logic          rbuf;
  logic [AW-1:0] raddr;

  logic          accept;
  logic          seal;
  logic [CW-1:0] seal_len;
  logic          out_hs;
  logic          is_last;
  logic          release_half;
  logic [1:0]    full_set;
  logic [1:0]    full_clr;
  logic          bram_rst;

  // ---------------------------------------------------------------- write side
  assign in_ready = !full[wbuf];
  assign accept   = in_valid && in_ready;
  assign seal_len = wcnt + CW'(accept);
  // A flush only seals when the half would hold at least one packet.
  assign seal     = (accept && (wcnt == LAST_IDX)) ||
                    (in_flush && ((wcnt != '0) || accept));

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbuf   <= 1'b0;
      wcnt   <= '0;
      len[0] <= '0;
      len[1] <= '0;
    end else if (seal) begin
      len[wbuf] <= seal_len;
      wbuf      <= ~wbuf;
      wcnt      <= '0;
    end else if (accept) begin
      wcnt <= wcnt + CW'(1);
    end
  end

  // Writer only seals a non-full half and the reader only releases a full one,
  // so a same-cycle set and clear always land on different halves.
  assign full_set = seal         ? (2'b01 << wbuf) : 2'b00;
  assign full_clr = release_half ? (2'b01 << rbuf) : 2'b00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 2'b00;
    end else begin
      full <= (full | full_set) & ~full_clr;
    end
  end

  // ----------------------------------------------------------------- read side
  assign out_hs       = (rstate == R_DATA) && out_ready;
  assign is_last      = ({1'b0, raddr} == (len[rbuf] - CW'(1)));
  assign release_half = out_hs && is_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rstate <= R_IDLE;
      rbuf   <= 1'b0;
      raddr  <= '0;
    end else begin
      rstate <= rstate_nxt;
      case (rstate)
        R_IDLE: if (full[rbuf]) raddr <= '0;
        R_DATA: begin
          if (out_hs) begin
            if (is_last) rbuf  <= ~rbuf;
            else         raddr <= raddr + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: every combinational output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    rstate_nxt = rstate;
    unique case (rstate)
      R_IDLE:  if (full[rbuf]) rstate_nxt = R_ADDR;
      R_ADDR:  rstate_nxt = R_DATA;
      R_DATA:  if (out_ready) rstate_nxt = is_last ? R_IDLE : R_ADDR;
      default: rstate_nxt = R_IDLE;
    endcase
  end

  // Outputs decode from registered state only, so reset clears out_valid at once.
  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_len   = '0;
    if (rstate == R_DATA) begin
      out_valid = 1'b1;
      out_last  = is_last;
      out_len   = len[rbuf];
    end
  end

  assign out_buf  = rbuf;
  assign bram_rst = !rst;

  // The read address is held through R_DATA, so out_data stays stable under
  // backpressure.
  dual_buffer_bram #(
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (AW)
  ) u_bram (
    .clk        (clk),
    .rst        (bram_rst),
    .wr_en      (accept),
    .wr_buf_sel (wbuf),
    .wr_addr    (wcnt[AW-1:0]),
    .wr_data    (in_data),
    .rd_buf_sel (rbuf),
    .rd_addr    (raddr),
    .rd_data    (out_data)
  );

endmodule

// File: tb/tb_dual_buffer_ctrl.sv
// Self-checking bench for dual_buffer_ctrl: table-driven fill/seal rows plus
// hand-written backpressure, empty-flush, random and mid-drain reset sequences.
module tb_dual_buffer_ctrl;
  import dual_buffer_pkg::*;

  localparam int DW = 16000;
  localparam int N  = 8;
  localparam int CW = count_width(N);

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [CW-1:0] out_len;
  logic          out_buf;

  int checks   = 0;
  int failures = 0;

  dual_buffer_ctrl #(
    .DATA_WIDTH             (DW),
    .NUM_PACKETS_PER_BUFFER (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_flush  (in_flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_len   (out_len),
    .out_buf   (out_buf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [CW-1:0] len;
    logic          obuf;
  } exp_t;

  typedef enum int {FL_NONE, FL_WITH_LAST, FL_AFTER} flush_t;

  typedef struct {
    int            n_pkts;
    flush_t        fl;
    logic [CW-1:0] exp_len;
    logic          exp_buf;
  } vec_t;

  exp_t exp_q[$];
  int   pend_q[$];
  logic m_wbuf;
  int   next_id;

  function automatic logic [DW-1:0] pay(input int id);
    logic [15:0] w;
    w = 16'(id);
    return {(DW/16){w}};
  endfunction

  task automatic check(input string name, input bit ok,
                       input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bail(input string name);
    check(name, 1'b0, 64'd0, 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  endtask

  // Output monitor: pops the expected queue on each handshake and checks that a
  // stalled packet is held unchanged.
  logic          stall_q = 1'b0;
  logic [DW-1:0] stall_data;
  exp_t          mon_e;

  always @(negedge clk) begin
    if (rst) begin
      if (stall_q) begin
        check("hold_valid", out_valid === 1'b1, 64'(out_valid), 64'd1);
        check("hold_data", out_data === stall_data, out_data[63:0], stall_data[63:0]);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1'b0, out_data[63:0], 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", out_data === mon_e.data, out_data[63:0], mon_e.data[63:0]);
          check("out_last", out_last === mon_e.last, 64'(out_last), 64'(mon_e.last));
          check("out_len",  out_len  === mon_e.len,  64'(out_len),  64'(mon_e.len));
          check("out_buf",  out_buf  === mon_e.obuf, 64'(out_buf),  64'(mon_e.obuf));
        end
      end
      stall_q    = out_valid && !out_ready;
      stall_data = out_data;
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic wait_in_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) bail("in_ready_timeout");
  endtask

  // Offer one packet (optionally with flush) and return #1 after it is accepted.
  task automatic write_pkt(input bit flush_now);
    int id;
    id = next_id;
    next_id++;
    in_valid = 1'b1;
    in_data  = pay(id);
    in_flush = flush_now;
    wait_in_ready();
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_flush = 1'b0;
    pend_q.push_back(id);
  endtask

  task automatic do_flush();
    in_flush = 1'b1;
    @(posedge clk); #1;
    in_flush = 1'b0;
  endtask

  task automatic seal_push(input int len, input logic obuf);
    exp_t e;
    for (int i = 0; i < pend_q.size(); i++) begin
      e.data = pay(pend_q[i]);
      e.last = (i == pend_q.size() - 1);
      e.len  = CW'(len);
      e.obuf = obuf;
      exp_q.push_back(e);
    end
    pend_q.delete();
    m_wbuf = ~obuf;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) bail("drain_timeout");
  endtask

  vec_t vecs[6];
  logic b0;
  int   id17;
  bit   seen;
  bit   found;
  bit   wr_done;
  int   r;

  initial begin
    // Fill/seal rows: packet count and flush style in, out_len and out_buf expected.
    vecs[0] = '{8, FL_NONE,      CW'(8), 1'b0};
    vecs[1] = '{8, FL_NONE,      CW'(8), 1'b1};
    vecs[2] = '{3, FL_AFTER,     CW'(3), 1'b0};
    vecs[3] = '{5, FL_WITH_LAST, CW'(5), 1'b1};
    vecs[4] = '{1, FL_WITH_LAST, CW'(1), 1'b0};
    vecs[5] = '{2, FL_AFTER,     CW'(2), 1'b1};

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_flush  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    next_id   = 0;
    m_wbuf    = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_in_ready",  in_ready  === 1'b1, 64'(in_ready),  64'd1);
    check("rst_out_valid", out_valid === 1'b0, 64'(out_valid), 64'd0);
    check("rst_out_last",  out_last  === 1'b0, 64'(out_last),  64'd0);
    check("rst_out_len",   out_len   === '0,   64'(out_len),   64'd0);
    check("rst_out_buf",   out_buf   === 1'b0, 64'(out_buf),   64'd0);
    @(posedge clk); #1;
    rst       = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Streaming, partial halves, flush on its own cycle and flush with the last accept
    for (int v = 0; v < 6; v++) begin
      for (int p = 0; p < vecs[v].n_pkts; p++)
        write_pkt(vecs[v].fl == FL_WITH_LAST && p == vecs[v].n_pkts - 1);
      if (vecs[v].fl == FL_AFTER) do_flush();
      seal_push(vecs[v].exp_len, vecs[v].exp_buf);
    end
    wait_drain();

    // Flush on an empty half produces nothing
    @(posedge clk); #1;
    do_flush();
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("empty_flush_no_output", !seen, 64'(seen), 64'd0);

    // One packet after the ignored flush: len 1, first out_valid two edges after the seal
    @(posedge clk); #1;
    write_pkt(1'b1);
    seal_push(1, m_wbuf);
    @(negedge clk);
    check("lat_seal_edge", out_valid === 1'b0, 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lat_one_edge", out_valid === 1'b0, 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lat_two_edges", out_valid === 1'b1, 64'(out_valid), 64'd1);
    wait_drain();

    // Both halves full under out_ready=0: the 17th packet stalls, then enters the freed half
    @(posedge clk); #1;
    out_ready = 1'b0;
    b0 = m_wbuf;
    for (int i = 0; i < N; i++) write_pkt(1'b0);
    seal_push(N, b0);
    for (int i = 0; i < N; i++) write_pkt(1'b0);
    seal_push(N, ~b0);
    @(negedge clk);
    check("both_full_in_ready", in_ready === 1'b0, 64'(in_ready), 64'd0);
    id17 = next_id;
    next_id++;
    in_valid = 1'b1;
    in_data  = pay(id17);
    repeat (4) @(negedge clk);
    check("stall_in_ready",  in_ready  === 1'b0, 64'(in_ready),  64'd0);
    check("stall_out_valid", out_valid === 1'b1, 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (out_valid && out_last) begin
        found = 1'b1;
        check("last_half_buf", out_buf === b0, 64'(out_buf), 64'(b0));
        check("in_ready_on_last", in_ready === 1'b0, 64'(in_ready), 64'd0);
        @(negedge clk);
        check("in_ready_after_release", in_ready === 1'b1, 64'(in_ready), 64'd1);
      end
    end
    if (!found) bail("release_timeout");
    @(posedge clk); #1;
    in_valid = 1'b0;
    pend_q.push_back(id17);
    do_flush();
    seal_push(1, b0);
    wait_drain();

    // Random backpressure with mixed flush styles against the scoreboard
    @(posedge clk); #1;
    wr_done = 1'b0;
    fork
      begin
        while (!wr_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
      begin
        for (int i = 0; i < 200; i++) begin
          r = int'($urandom_range(0, 9));
          if (r == 0) begin
            @(posedge clk); #1;
          end
          write_pkt(r == 1);
          if (r == 1 || pend_q.size() == N) begin
            seal_push(pend_q.size(), m_wbuf);
          end else if (r == 2) begin
            do_flush();
            seal_push(pend_q.size(), m_wbuf);
          end
        end
        if (pend_q.size() != 0) begin
          do_flush();
          seal_push(pend_q.size(), m_wbuf);
        end
        wr_done = 1'b1;
      end
    join
    out_ready = 1'b1;
    wait_drain();

    // Reset while half 0 is presenting data, then a clean refill of ping
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst       = 1'b1;
    out_ready = 1'b0;
    m_wbuf    = 1'b0;
    for (int i = 0; i < N; i++) write_pkt(1'b0);
    seal_push(N, 1'b0);
    found = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      @(negedge clk);
      if (out_valid) found = 1'b1;
    end
    if (!found) bail("pre_reset_valid_timeout");
    check("pre_reset_buf", out_buf === 1'b0, 64'(out_buf), 64'd0);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid === 1'b0, 64'(out_valid), 64'd0);
    check("async_rst_in_ready",  in_ready  === 1'b1, 64'(in_ready),  64'd1);
    check("async_rst_out_len",   out_len   === '0,   64'(out_len),   64'd0);
    exp_q.delete();
    pend_q.delete();
    m_wbuf = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst       = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) write_pkt(1'b0);
    seal_push(N, 1'b0);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
